// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared memory-system types: arbiter states, owner encoding, widths
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int C_DEFAULT_AW = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Fetch port, data port and shared-memory port bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = mem_arbiter_pkg::C_DEFAULT_AW
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ack;

    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    // Arbiter side: serves both clients, masters the memory
    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_wr, mem_addr, mem_wdata
    );

endinterface : mem_arbiter_if

`default_nettype wire

// File: rtl/mem_arbiter_arb_prio.sv
// ============================================================================
// Module  : arb_prio
// Brief   : Grant decision with data priority and instruction anti-starvation
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   i_instr_req,
    input  wire logic   i_data_req,
    input  wire logic   i_grant_en,
    output logic        o_grant,
    output owner_t      o_grant_owner
);

    localparam int              C_SW     = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
    localparam logic [C_SW-1:0] C_STARVE = C_SW'(STARVE);

    logic [C_SW-1:0] r_starve_cnt;
    logic            w_data_wins;

    // Data wins ties until the fetch side has been passed over STARVE times
    assign w_data_wins   = i_data_req && !(i_instr_req && (r_starve_cnt == C_STARVE));
    assign o_grant       = i_grant_en && (i_instr_req || i_data_req);
    assign o_grant_owner = w_data_wins ? OWN_DATA : OWN_INSTR;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (o_grant) begin
            if (!w_data_wins) begin
                r_starve_cnt <= '0;
            end else if (i_instr_req && (r_starve_cnt != C_STARVE)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule : arb_prio

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-client (fetch/data) arbiter onto a single-port memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW     = C_DEFAULT_AW,
    parameter int STARVE = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_arbiter_if.master  bus
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    owner_t        r_owner;
    logic [AW-1:0] r_addr;
    logic          r_wr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_i_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_grant;
    owner_t        w_grant_owner;

    arb_prio #(
        .STARVE (STARVE)
    ) u_arb_prio (
        .clk           (clk),
        .reset         (reset),
        .i_instr_req   (bus.i_req),
        .i_data_req    (bus.d_req),
        .i_grant_en    (r_state == ST_IDLE),
        .o_grant       (w_grant),
        .o_grant_owner (w_grant_owner)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant)     w_state_nxt = ST_BUSY;
            ST_BUSY: if (bus.mem_ack) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_INSTR;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DATA) begin
                    r_addr  <= bus.d_addr;
                    r_wr    <= bus.d_wr;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_addr  <= bus.i_addr;
                    r_wr    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            // Write completions also capture mem_rdata into d_rdata
            if ((r_state == ST_BUSY) && bus.mem_ack) begin
                if (r_owner == OWN_DATA) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_i_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = (r_state == ST_BUSY);
    assign bus.mem_wr    = r_wr;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.i_ack     = (r_state == ST_DONE) && (r_owner == OWN_INSTR);
    assign bus.d_ack     = (r_state == ST_DONE) && (r_owner == OWN_DATA);
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Self-checking bench for mem_arbiter against a transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW     = 10;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW)) bus();

    mem_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- transaction-level reference model ----------------
    // m_phase: 0 = waiting for requests, 1 = memory access outstanding,
    // 2 = completion cycle toward the owner
    int            m_phase  = 0;
    bit            m_own_d  = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic          m_wr     = 1'b0;
    logic [31:0]   m_wdata  = '0;
    logic [31:0]   m_ird    = '0;
    logic [31:0]   m_drd    = '0;
    int            m_starve = 0;
    bit            m_valid  = 1'b0;
    string         m_log    = "";

    always @(posedge clk) begin
        bit pick_d;
        if (reset) begin
            m_phase = 0; m_starve = 0; m_own_d = 1'b0;
            m_addr = '0; m_wr = 1'b0; m_wdata = '0; m_ird = '0; m_drd = '0;
        end else if (m_phase == 0) begin
            if (bus.i_req || bus.d_req) begin
                pick_d = bus.d_req && !(bus.i_req && (m_starve == STARVE));
                if (pick_d) begin
                    if (bus.i_req) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
                    m_own_d = 1'b1; m_addr = bus.d_addr; m_wr = bus.d_wr; m_wdata = bus.d_wdata;
                    m_log = {m_log, "D"};
                end else begin
                    m_starve = 0;
                    m_own_d = 1'b0; m_addr = bus.i_addr; m_wr = 1'b0; m_wdata = '0;
                    m_log = {m_log, "I"};
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (bus.mem_ack) begin
                if (m_own_d) m_drd = bus.mem_rdata;
                else         m_ird = bus.mem_rdata;
                m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
        m_valid = 1'b1;
    end

    // ---------------- memory responder ----------------
    int          cfg_lat    = 0;
    bit          cfg_rand   = 1'b0;
    logic [31:0] cfg_rdata  = '0;
    int          stray_req  = 0;

    initial begin
        int wcnt;
        int cur_lat;
        int stray_done;
        wcnt = 0; cur_lat = 0; stray_done = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (bus.mem_req) begin
                if (wcnt >= (cfg_rand ? cur_lat : cfg_lat)) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = cfg_rand ? 32'($urandom) : cfg_rdata;
                    wcnt    = 0;
                    cur_lat = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                if (stray_done != stray_req) begin
                    stray_done++;
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'($urandom);
                end
            end
        end
    end

    // ---------------- checking helpers (all called from the main process) ----------------
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic lit_str(input string name, input string act, input string exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end
    endtask

    task automatic cycle_check();
        logic e_req, e_iack, e_dack;
        if (!m_valid) return;
        e_req  = (m_phase == 1);
        e_iack = (m_phase == 2) && !m_own_d;
        e_dack = (m_phase == 2) && m_own_d;
        vectors++;
        if (bus.mem_req !== e_req || bus.mem_wr !== m_wr || bus.mem_addr !== m_addr ||
            bus.mem_wdata !== m_wdata || bus.i_ack !== e_iack || bus.d_ack !== e_dack ||
            bus.i_rdata !== m_ird || bus.d_rdata !== m_drd) begin
            miscompares++;
            $display("FAIL cycle t=%0t got/exp req=%b/%b wr=%b/%b addr=%h/%h wdata=%h/%h iack=%b/%b dack=%b/%b ird=%h/%h drd=%h/%h",
                     $time, bus.mem_req, e_req, bus.mem_wr, m_wr, bus.mem_addr, m_addr,
                     bus.mem_wdata, m_wdata, bus.i_ack, e_iack, bus.d_ack, e_dack,
                     bus.i_rdata, m_ird, bus.d_rdata, m_drd);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
    endtask

    int            o_req, o_iack, o_dack, o_first;
    bit            o_bad;
    logic [AW-1:0] o_addr;
    logic          o_wr;
    logic [31:0]   o_wdata, o_ird, o_drd;

    // Runs n cycles, gathering what the DUT did; a client drops its request on its ack
    task automatic observe(input int n);
        o_req = 0; o_iack = 0; o_dack = 0; o_first = -1; o_bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.mem_req) begin
                if (o_req == 0) begin
                    o_first = k; o_addr = bus.mem_addr; o_wr = bus.mem_wr; o_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== o_addr || bus.mem_wr !== o_wr || bus.mem_wdata !== o_wdata) begin
                    o_bad = 1'b1;
                end
                o_req++;
            end
            if (bus.i_ack) begin o_iack++; o_ird = bus.i_rdata; bus.i_req = 1'b0; end
            if (bus.d_ack) begin o_dack++; o_drd = bus.d_rdata; bus.d_req = 1'b0; end
        end
    endtask

    // Both clients request continuously; returns the order of the next n completions
    task automatic collect(input int n, output string s);
        int guard;
        s = "";
        guard = 0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        while (s.len() < n && guard < n * 10) begin
            tick();
            guard++;
            if (bus.i_ack) begin s = {s, "I"}; bus.i_addr = AW'($urandom); end
            if (bus.d_ack) begin s = {s, "D"}; bus.d_addr = AW'($urandom); bus.d_wdata = 32'($urandom); end
        end
        if (s.len() < n) lit("collect_timeout", 64'(s.len()), 64'(n));
    endtask

    // ---------------- main stimulus / compare process ----------------
    initial begin
        string s;
        int    log_start;
        int    guard;

        reset = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        lit("rst_mem_req_wr", {62'd0, bus.mem_req, bus.mem_wr}, 64'd0);
        lit("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        lit("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        lit("rst_acks", {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
        lit("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);

        // Lone fetch, two wait cycles before the memory answers
        cfg_lat = 2; cfg_rdata = 32'h2008000A;
        bus.i_req = 1'b1; bus.i_addr = 10'h005;
        observe(8);
        lit("fetch_first_req", 64'(o_first), 64'd0);
        lit("fetch_busy_cycles", 64'(o_req), 64'd3);
        lit("fetch_addr_wr", {53'd0, o_wr, o_addr}, {53'd0, 1'b0, 10'h005});
        lit("fetch_acks", {32'(o_iack), 32'(o_dack)}, {32'd1, 32'd0});
        lit("fetch_rdata", 64'(o_ird), 64'h2008000A);

        // Lone write
        cfg_lat = 1; cfg_rdata = 32'h12345678;
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 10'h03F; bus.d_wdata = 32'hDEADBEEF;
        observe(8);
        lit("write_busy_cycles", 64'(o_req), 64'd2);
        lit("write_mem_fields", {21'd0, o_wr, o_addr, o_wdata}, {21'd0, 1'b1, 10'h03F, 32'hDEADBEEF});
        lit("write_hold_stable", 64'(o_bad), 64'd0);
        lit("write_acks", {32'(o_iack), 32'(o_dack)}, {32'd0, 32'd1});
        lit("write_drdata", 64'(o_drd), 64'h12345678);
        bus.d_wr = 1'b0;

        // Stray memory ack while idle
        stray_req++;
        observe(5);
        lit("stray_nothing", {32'(o_req), 16'(o_iack), 16'(o_dack)}, 64'd0);

        // Fetch request raised and withdrawn while a data read is in flight
        cfg_lat = 3;
        bus.d_req = 1'b1; bus.d_addr = 10'h010;
        tick(); tick();
        bus.i_req = 1'b1; bus.i_addr = 10'h022;
        tick();
        bus.i_req = 1'b0;
        observe(8);
        lit("drop_acks", {32'(o_iack), 32'(o_dack)}, {32'd0, 32'd1});

        // Contention with immediate memory: anti-starvation order
        cfg_lat = 0;
        log_start = m_log.len();
        collect(10, s);
        lit_str("contention_dut", s, "DDDDIDDDDI");
        lit_str("contention_model", m_log.substr(log_start, log_start + 9), "DDDDIDDDDI");
        collect(2, s);
        lit_str("contention_more", s, "DD");

        // Reset in the middle of the next data access
        cfg_lat = 6;
        guard = 0;
        do begin tick(); guard++; end while (!bus.mem_req && guard < 10);
        lit("reset_test_busy_reached", 64'(bus.mem_req), 64'd1);
        reset = 1'b1; bus.i_req = 1'b0; bus.d_req = 1'b0;
        tick();
        reset = 1'b0;
        lit("reset_mid_busy_req", {62'd0, bus.mem_req, bus.i_ack | bus.d_ack}, 64'd0);
        observe(6);
        lit("reset_no_ack", {32'(o_req), 16'(o_iack), 16'(o_dack)}, 64'd0);
        cfg_lat = 0;
        collect(5, s);
        lit_str("reset_starve_cleared", s, "DDDDI");
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        observe(4);

        // Randomized traffic with random latency, stray acks, drops and resets
        cfg_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (bus.i_ack) bus.i_req = 1'b0;
            if (bus.d_ack) bus.d_req = 1'b0;
            if (!bus.i_req) begin
                if ($urandom_range(0, 2) == 0) begin bus.i_req = 1'b1; bus.i_addr = AW'($urandom); end
            end else if ($urandom_range(0, 60) == 0) begin
                bus.i_req = 1'b0;
            end
            if (!bus.d_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.d_req = 1'b1; bus.d_wr = 1'($urandom);
                    bus.d_addr = AW'($urandom); bus.d_wdata = 32'($urandom);
                end
            end else if ($urandom_range(0, 60) == 0) begin
                bus.d_req = 1'b0;
            end
            if ($urandom_range(0, 30) == 0) stray_req++;
            reset = ($urandom_range(0, 400) == 0);
        end
        reset = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10: address width of all address ports.
REQ-002 Parameter STARVE, default 4: consecutive data grants allowed while an instruction request waits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request, read-only; held until i_ack.
REQ-006 i_addr  input  AW  fetch word address.
REQ-007 i_rdata  output  32  fetched word, valid while i_ack=1.
REQ-008 i_ack  output  1  one-cycle completion pulse to fetch port.
REQ-009 d_req  input  1  data request; held until d_ack.
REQ-010 d_wr  input  1  1=write, 0=read; qualified by d_req.
REQ-011 d_addr  input  AW  data word address.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_rdata  output  32  read word, valid while d_ack=1.
REQ-014 d_ack  output  1  one-cycle completion pulse to data port.
REQ-015 mem_req  output  1  request to the shared single-port memory; held until mem_ack.
REQ-016 mem_wr  output  1  write strobe accompanying mem_req.
REQ-017 mem_addr  output  AW  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-020 mem_ack  input  1  memory completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, BUSY, DONE.
REQ-022 In IDLE with any request, the arbiter SHALL grant one requester, latch its address, wr flag (0 for fetch) and wdata into registers, record the owner, and enter BUSY next cycle.
REQ-023 mem_req, mem_wr, mem_addr, mem_wdata SHALL be driven only from the latched registers, mem_req=1 exactly while in BUSY; first mem_req cycle is one cycle after the granting IDLE cycle.
REQ-024 In BUSY, mem_ack=1 SHALL capture mem_rdata into the owner's rdata register and move to DONE; mem_ack=0 SHALL hold BUSY with all mem_* outputs unchanged, no timeout.
REQ-025 In DONE, the owner's ack SHALL be 1 for exactly that cycle, no grant SHALL occur, and the state SHALL return to IDLE next cycle; minimum transaction is 3 cycles (IDLE, BUSY, DONE) plus memory wait.
REQ-026 i_ack and d_ack SHALL never both be 1; the non-owner's ack SHALL be 0.
REQ-027 i_rdata/d_rdata SHALL hold their last captured values between transactions; d_rdata after a write SHALL be the mem_rdata sampled on that mem_ack.
REQ-028 Priority: if only one request is high, that requester SHALL win; if both, data SHALL win unless starve_cnt==STARVE, in which case instruction SHALL win.
REQ-029 starve_cnt (width clog2(STARVE+1)) SHALL increment, saturating at STARVE, on each data grant made while i_req=1, and SHALL clear on every instruction grant; it is unchanged otherwise.
REQ-030 Request drop: a requester deasserting req while pending in IDLE SHALL simply lose the grant; once granted, the transaction SHALL complete regardless of the req level.
REQ-031 mem_ack while not in BUSY SHALL be ignored.

Reset
REQ-032 Reset SHALL force state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, starve_cnt=0, owner=instruction.
REQ-033 Reset asserted mid-transaction SHALL abandon it: no ack SHALL be issued for it, and mem_req SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-034 State encoding (IDLE/BUSY/DONE) and owner encoding SHALL live in the shared memory-system package with the default AW.
REQ-035 One sub-module, arb_prio, SHALL hold starve_cnt and the grant decision (REQ-028/029); the FSM and datapath registers SHALL stay in mem_arbiter.

Verification
REQ-036 Lone fetch: i_req=1, i_addr=0x005, mem_ack after 2 BUSY cycles with mem_rdata=0x2008000A -> mem_req one cycle after grant, i_ack pulse one cycle with i_rdata=0x2008000A, d_ack=0.
REQ-037 Lone write: d_req=1, d_wr=1, d_addr=0x3F, d_wdata=0xDEADBEEF -> mem_wr=1, mem_addr=0x3F, mem_wdata=0xDEADBEEF held through BUSY; single d_ack.
REQ-038 Contention: both req held continuously, STARVE=4, mem_ack immediate -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Reset mid-BUSY: reset for one cycle while mem_req=1 -> mem_req=0 next cycle, no i_ack/d_ack for that transaction, starve_cnt=0.
REQ-040 Stray/early events: mem_ack pulsed in IDLE -> no ack, no state change; i_req dropped before grant while d_req=1 -> data transaction only.
